// File: rtl/rr_arb8_4bit.sv
`default_nettype none
// ============================================================================
// rr_arb8_4bit -- 8-way round-robin arbiter, registered 4-bit word, valid/ready
// handshake and one-hot grant pulse per accepted word.            rev 1.0
// ============================================================================
module rr_arb8_4bit (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] REQ,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] E,
  input  logic [3:0] F,
  input  logic [3:0] G,
  input  logic [3:0] H,
  input  logic       READY,
  output logic       VALID,
  output logic [3:0] Y,
  output logic [2:0] S,
  output logic [7:0] GNT
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_y;
  logic [2:0] r_s;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;

  logic [3:0] w_data [8];
  logic [2:0] w_win;
  logic       w_load;
  logic       w_xfer;

  assign w_data[0] = A;
  assign w_data[1] = B;
  assign w_data[2] = C;
  assign w_data[3] = D;
  assign w_data[4] = E;
  assign w_data[5] = F;
  assign w_data[6] = G;
  assign w_data[7] = H;

  // Scan from the highest offset down so the nearest set bit after r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      if (REQ[r_ptr + 3'(k)]) begin
        w_win = r_ptr + 3'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|REQ) begin
          w_load      = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (READY) begin
          w_xfer      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_y     <= 4'b0000;
      r_s     <= 3'b000;
      r_ptr   <= 3'b000;
      r_gnt   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_s <= w_win;
        r_y <= w_data[w_win];
      end
      r_gnt <= w_xfer ? (8'd1 << r_s) : 8'd0;
      if (w_xfer) begin
        r_ptr <= r_s + 3'd1;
      end
    end
  end

  assign VALID = (r_state == ST_BUSY);
  assign Y     = r_y;
  assign S     = r_s;
  assign GNT   = r_gnt;

endmodule
`default_nettype wire

// File: doc/rr_arb8_4bit.md
RR_ARB8_4BIT -- requirements
Module: rr_arb8_4bit

Interface
REQ-001 Parameters: none; data width is fixed at 4 bits, requester count is fixed at 8.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 REQ  input  8  per-requester request; bit i belongs to requester i (0=A ... 7=H).
REQ-005 A,B,C,D,E,F,G,H  input  4 each  requester data words.
REQ-006 READY  input  1  downstream consumer can accept Y this cycle.
REQ-007 VALID  output  1  Y holds a granted word awaiting acceptance.
REQ-008 Y  output  4  registered selected data word.
REQ-009 S  output  3  registered index of the current/last winner (drives the 8:1 4-bit mux select).
REQ-010 GNT  output  8  one-hot, one-cycle pulse to the requester whose word was accepted.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (VALID=0) and BUSY (VALID=1).
REQ-012 IDLE with REQ==0: remain in IDLE; Y, S and PTR hold.
REQ-013 IDLE with REQ!=0: the winner SHALL be the first set bit found scanning PTR, PTR+1, ... mod 8; on that edge load S=winner, Y=data of winner, then enter BUSY.
REQ-014 Latency: REQ sampled at edge N -> VALID=1 with valid Y/S after edge N.
REQ-015 BUSY: Y and S SHALL remain stable regardless of REQ or A..H changes, until transfer.
REQ-016 Transfer is VALID&&READY at a rising edge; on that edge: GNT[S]=1 for exactly the following cycle, PTR=(S+1) mod 8, state->IDLE.
REQ-017 READY while IDLE SHALL be ignored; no GNT is issued without a transfer.
REQ-018 GNT SHALL be 0 in every cycle except the one after a transfer; never more than one bit set.
REQ-019 Maximum throughput is one transfer per 2 cycles (arbitration in IDLE, transfer in BUSY); no back-to-back grants.
REQ-020 PTR wrap: winner 7 -> PTR=0; scan wraps 7->0 in REQ-013.
REQ-021 A requester deasserting REQ while its word is held in BUSY SHALL NOT cancel the transfer; GNT is still issued.
REQ-022 The winner's REQ still high after GNT is treated as a new request with lowest priority (PTR has advanced past it).
REQ-023 Fairness: with all 8 REQ held high and READY=1, S SHALL cycle 0,1,...,7,0 on successive grants from reset.
REQ-024 The S-to-data mapping SHALL be 0->A, 1->B, 2->C, 3->D, 4->E, 5->F, 6->G, 7->H.

Reset
REQ-025 RST_N=0 at a rising edge SHALL force: state=IDLE, VALID=0, Y=4'b0000, S=3'b000, GNT=8'h00, PTR=0.
REQ-026 Reset asserted during BUSY SHALL discard the held word with no GNT issued; after release, arbitration restarts from PTR=0.
REQ-027 While RST_N=0, REQ and READY SHALL have no effect.

Verification
REQ-028 Reset, REQ=8'h00 for 5 cycles -> VALID=0, Y=0000, S=000, GNT=00 throughout.
REQ-029 From reset, REQ=8'b0000_0100, C=4'b0111, READY=0 for 3 cycles then 1 -> VALID=1 after first edge, Y=0111, S=010 stable; GNT=8'b0000_0100 for one cycle after the READY edge; VALID=0.
REQ-030 From reset, REQ=8'hFF held, A=1000,B=0101,C=0111,D=1001,E=1100,F=1110,G=0001,H=1011, READY=1 -> Y sequence 1000,0101,0111,1001,1100,1110,0001,1011,1000; S 0..7,0; one grant per 2 cycles.
REQ-031 PTR=6 (after winner 5), REQ=8'b0000_0011 -> winner 0 (wrap), S=000; next grant goes to 1.
REQ-032 BUSY holding S=011, Y=1001; drop REQ[3] and change D=0000 -> Y stays 1001; transfer still produces GNT[3]=1.
REQ-033 BUSY with S=101, RST_N=0 for one edge -> VALID=0, Y=0000, S=000, GNT never pulses; with REQ=8'b0010_0001 after release -> winner 0.
